// File: rtl/muldiv_wb.sv
// Iterative RV32M multiply/divide unit writing its result straight into the register file.
// Latency: accept edge is edge 0; wreq is high after edge 34 and ready returns after edge 35.
// Backpressure: one op in flight; start is only taken while ready=1; kill abandons the op.
module muldiv_wb #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   output logic            ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [3:0]      rd,
   input  logic            kill,
   output logic            busy,
   output logic [3:0]      pend_rd,
   output logic            wreq,
   output logic [3:0]      windex,
   output logic [XLEN-1:0] wdata
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic [3:0]        rd_q, rd_d;
   logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d, bzero_q, bzero_d;
   // hi/lo hold {accumulator, multiplier} for multiply and {remainder, quotient} for divide
   logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
   logic              ready_q, ready_d, busy_q, busy_d, wreq_q, wreq_d;
   logic [3:0]        pend_q, pend_d, windex_q, windex_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;

   logic              accept, signed_a, signed_b, neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b, dsub;
   logic [XLEN:0]     madd, dshift;
   logic              dge;
   logic [2*XLEN-1:0] prod, sprod;

   // Operand decode, one shift-add / shift-subtract step, and sign correction of the final product
   always_comb begin
      accept   = ready_q & start & ~kill;
      signed_a = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]);
      signed_b = (funct3 == 3'b001) | (funct3[2] & ~funct3[0]);
      neg_a    = signed_a & rs1_val[XLEN-1];
      neg_b    = signed_b & rs2_val[XLEN-1];
      mag_a    = neg_a ? -rs1_val : rs1_val;
      mag_b    = neg_b ? -rs2_val : rs2_val;
      madd     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
      dshift   = {hi_q, lo_q[XLEN-1]};
      dge      = dshift >= {1'b0, b_q};
      // the partial remainder always stays below the divisor, so XLEN bits of difference suffice
      dsub     = dshift[XLEN-1:0] - b_q;
      prod     = {hi_q, lo_q};
      sprod    = (neg_a_q ^ neg_b_q) ? -prod : prod;
   end

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      rd_d     = rd_q;
      neg_a_d  = neg_a_q;
      neg_b_d  = neg_b_q;
      bzero_d  = bzero_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      b_d      = b_q;
      res_d    = res_q;
      windex_d = windex_q;
      wdata_d  = wdata_q;
      wreq_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = CALC;
               cnt_d   = 5'd0;
               f3_d    = funct3;
               rd_d    = rd;
               neg_a_d = neg_a;
               neg_b_d = neg_b;
               bzero_d = (rs2_val == '0);
               hi_d    = '0;
               if (funct3[2]) begin
                  lo_d = mag_a;
                  b_d  = mag_b;
               end else begin
                  lo_d = mag_b;
                  b_d  = mag_a;
               end
            end
         end
         CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (f3_q[2]) begin
               hi_d = dge ? dsub : dshift[XLEN-1:0];
               lo_d = {lo_q[XLEN-2:0], dge};
            end else begin
               hi_d = madd[XLEN:1];
               lo_d = {madd[0], lo_q[XLEN-1:1]};
            end
            if (cnt_q == 5'd31) state_d = FIX;
         end
         FIX: begin
            state_d = DONE;
            case (f3_q)
               3'b000:                 res_d = sprod[XLEN-1:0];
               3'b001, 3'b010, 3'b011: res_d = sprod[2*XLEN-1:XLEN];
               // divide-by-zero yields all ones even when the dividend is negative
               3'b100, 3'b101:         res_d = bzero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -lo_q : lo_q);
               default:                res_d = neg_a_q ? -hi_q : hi_q;
            endcase
         end
         DONE: begin
            state_d  = IDLE;
            windex_d = rd_q;
            wdata_d  = res_q;
            wreq_d   = (rd_q != 4'd0);
         end
         default: state_d = IDLE;
      endcase
      if (kill && state_q != IDLE) begin
         state_d = IDLE;
         wreq_d  = 1'b0;
      end
      // ready drops on the accept edge itself so a second start is never offered a false ready
      ready_d = accept ? 1'b0 : ((state_q == IDLE) | kill);
      busy_d  = ~ready_d;
      pend_d  = ready_d ? 4'd0 : (accept ? rd : rd_q);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         f3_q     <= '0;
         rd_q     <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         bzero_q  <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         b_q      <= '0;
         res_q    <= '0;
         ready_q  <= 1'b1;
         busy_q   <= 1'b0;
         pend_q   <= '0;
         wreq_q   <= 1'b0;
         windex_q <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         rd_q     <= rd_d;
         neg_a_q  <= neg_a_d;
         neg_b_q  <= neg_b_d;
         bzero_q  <= bzero_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         b_q      <= b_d;
         res_q    <= res_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         wreq_q   <= wreq_d;
         windex_q <= windex_d;
         wdata_q  <= wdata_d;
      end
   end

   assign ready   = ready_q;
   assign busy    = busy_q;
   assign pend_rd = pend_q;
   assign wreq    = wreq_q;
   assign windex  = windex_q;
   assign wdata   = wdata_q;

endmodule

// File: tb/tb_muldiv_wb.sv
// Directed bench for muldiv_wb: arithmetic results, write-port timing, kill, rd=0 and reset.
// Expected values are hand-computed constants; outputs sampled 1ns after the rising edge.
// Inputs are driven on the falling edge or 1ns after the rising edge.
module tb_muldiv_wb;
   logic        clk = 1'b0;
   logic        rstn, start, kill;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic [3:0]  rd;
   logic        ready, busy, wreq;
   logic [3:0]  pend_rd, windex;
   logic [31:0] wdata;

   int errors = 0;
   int checks = 0;

   muldiv_wb #(.XLEN(32)) dut (
      .clk(clk), .rstn(rstn), .start(start), .ready(ready), .funct3(funct3),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd(rd), .kill(kill), .busy(busy),
      .pend_rd(pend_rd), .wreq(wreq), .windex(windex), .wdata(wdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present one op and leave the bench 1ns after the accept edge (edge 0)
   task automatic accept_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] r);
      @(negedge clk);
      funct3 = f; rs1_val = a; rs2_val = b; rd = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      rs1_val = ~a;
      rs2_val = 32'h5a5a_1234;
   endtask

   // Run a full op and check write-port timing and data; mode 1 also pulses start mid-CALC
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] r, input logic [31:0] exp,
                         input int mode);
      int wcnt;
      wcnt = 0;
      accept_op(f, a, b, r);
      check({tag, "_ready_acc"}, 32'(ready), 32'd0);
      check({tag, "_busy_acc"}, 32'(busy), 32'd1);
      for (int n = 1; n <= 35; n++) begin
         if (mode == 1 && n == 5) begin
            start = 1'b1; funct3 = 3'b000; rd = 4'hf;
            rs1_val = 32'd3; rs2_val = 32'd3;
         end
         if (n == 6) start = 1'b0;
         @(posedge clk); #1;
         if (wreq) wcnt++;
         if (n == 20) check({tag, "_pend_rd"}, 32'(pend_rd), 32'(r));
         if (n == 33) check({tag, "_wreq_early"}, 32'(wreq), 32'd0);
         if (n == 34) begin
            check({tag, "_wreq"}, 32'(wreq), 32'(r != 4'd0));
            check({tag, "_windex"}, 32'(windex), 32'(r));
            check({tag, "_wdata"}, wdata, exp);
            check({tag, "_ready_wr"}, 32'(ready), 32'd0);
         end
      end
      check({tag, "_wreq_cnt"}, 32'(wcnt), 32'(r != 4'd0));
      check({tag, "_ready_end"}, 32'(ready), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_pend_end"}, 32'(pend_rd), 32'd0);
   endtask

   initial begin
      int wcnt;
      rstn = 1'b0; start = 1'b0; kill = 1'b0;
      funct3 = 3'b000; rs1_val = '0; rs2_val = '0; rd = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_wreq", 32'(wreq), 32'd0);
      check("rst_pend", 32'(pend_rd), 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      run_op("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 4'd5,  32'hFFFF_FFEB, 0);
      run_op("mulh",   3'b001, 32'd7,          32'hFFFF_FFFD, 4'd5,  32'hFFFF_FFFF, 0);
      run_op("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 4'd7,  32'hFFFF_FFFE, 0);
      run_op("mulhsu", 3'b010, 32'd2,          32'hFFFF_FFFF, 4'd8,  32'h0000_0001, 0);
      run_op("div",    3'b100, 32'hFFFF_FFF9,  32'd2,         4'd1,  32'hFFFF_FFFD, 0);
      run_op("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,         4'd2,  32'hFFFF_FFFF, 0);
      run_op("divu",   3'b101, 32'd100,        32'd7,         4'd3,  32'd14,        0);
      run_op("remu",   3'b111, 32'd100,        32'd7,         4'd4,  32'd2,         0);
      run_op("div0",   3'b100, 32'd5,          32'd0,         4'd6,  32'hFFFF_FFFF, 0);
      run_op("rem0",   3'b110, 32'd5,          32'd0,         4'd6,  32'd5,         0);
      run_op("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 4'd9,  32'h8000_0000, 0);
      run_op("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 4'd9,  32'd0,         0);
      run_op("rd0",    3'b000, 32'd3,          32'd4,         4'd0,  32'd12,        0);
      run_op("ignst",  3'b101, 32'd100,        32'd7,         4'd11, 32'd14,        1);

      // start together with kill in IDLE must not be accepted
      @(negedge clk);
      funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; rd = 4'd4;
      start = 1'b1; kill = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      check("idlekill_ready", 32'(ready), 32'd1);
      check("idlekill_busy", 32'(busy), 32'd0);

      // kill in CALC cycle 10
      accept_op(3'b000, 32'd3, 32'd4, 4'd6);
      repeat (10) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("killc_ready", 32'(ready), 32'd1);
      check("killc_busy", 32'(busy), 32'd0);
      check("killc_pend", 32'(pend_rd), 32'd0);
      wcnt = 0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk); #1;
         if (wreq) wcnt++;
      end
      check("killc_nowreq", 32'(wcnt), 32'd0);
      run_op("afterkill", 3'b101, 32'd100, 32'd7, 4'd9, 32'd14, 0);

      // kill in the DONE cycle suppresses the write
      accept_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3);
      repeat (33) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      check("killd_wreq", 32'(wreq), 32'd0);
      @(posedge clk); #1;
      check("killd_wreq2", 32'(wreq), 32'd0);
      check("killd_ready", 32'(ready), 32'd1);

      // synchronous reset mid-CALC
      accept_op(3'b000, 32'd7, 32'd9, 4'd12);
      repeat (5) @(posedge clk);
      #1 rstn = 1'b0;
      @(posedge clk); #1;
      check("rstc_ready", 32'(ready), 32'd1);
      check("rstc_busy", 32'(busy), 32'd0);
      check("rstc_pend", 32'(pend_rd), 32'd0);
      check("rstc_wreq", 32'(wreq), 32'd0);
      check("rstc_windex", 32'(windex), 32'd0);
      check("rstc_wdata", wdata, 32'd0);
      rstn = 1'b1;
      run_op("afterrst", 3'b000, 32'd6, 32'd7, 4'd13, 32'd42, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
